// File: rtl/led_frame_expander.sv
// Latches one frame of per-bin colors and LED counts, then streams exactly LEDS
// pixel colors over a valid/ready handshake. Bin 0 fills the lowest indices.
module led_frame_expander #(
    parameter int LEDS    = 50,
    parameter int BIN_QTY = 12,
    parameter int CW      = $clog2(LEDS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [BIN_QTY-1:0][23:0]        rgb_i,
    input  logic [BIN_QTY-2:0][CW-1:0]      LEDCounts_i,
    input  logic                            start_i,
    output logic [23:0]                     pixel_o,
    output logic [CW-1:0]                   pixel_index_o,
    output logic                            pixel_valid_o,
    output logic                            pixel_last_o,
    input  logic                            pixel_ready_i,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int SW = CW + $clog2(BIN_QTY);
    localparam int BW = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [BIN_QTY-1:0][23:0]      rgb_q, rgb_d;
    logic [BIN_QTY-1:0][CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]                 bin_q, bin_d;
    logic [CW-1:0]                 rem_q, rem_d;
    logic [CW-1:0]                 pix_cnt_q, pix_cnt_d;

    logic [23:0]                   pixel_q, pixel_d;
    logic [CW-1:0]                 index_q, index_d;
    logic                          valid_q, valid_d;
    logic                          last_q, last_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

    logic [SW-1:0]                 psum [BIN_QTY];
    logic [BW-1:0]                 bin_nx;
    logic [CW-1:0]                 last_bin_cnt;
    logic                          slot_free;

    // psum[k] is the total pixel count of bins 0..k-1
    assign psum[0] = '0;
    generate
        for (genvar gi = 0; gi < BIN_QTY - 1; gi++) begin : g_psum
            assign psum[gi+1] = psum[gi] + SW'(cnt_q[gi]);
        end
    endgenerate

    assign last_bin_cnt = (psum[BIN_QTY-1] < SW'(LEDS))
                        ? CW'(SW'(LEDS) - psum[BIN_QTY-1]) : '0;

    // Saturate at the last bin; reaching past it only happens on the final pixel.
    assign bin_nx = (bin_q == BW'(BIN_QTY - 1)) ? bin_q : bin_q + BW'(1);

    always_comb begin
        state_d   = state_q;
        rgb_d     = rgb_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        rem_d     = rem_q;
        pix_cnt_d = pix_cnt_q;
        pixel_d   = pixel_q;
        index_d   = index_q;
        valid_d   = valid_q;
        last_d    = last_q;
        done_d    = 1'b0;
        slot_free = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rgb_d                = rgb_i;
                    cnt_d[BIN_QTY-2:0]   = LEDCounts_i;
                    cnt_d[BIN_QTY-1]     = '0;
                    bin_d                = '0;
                    rem_d                = '0;
                    pix_cnt_d            = '0;
                    state_d              = LOAD;
                end
            end

            LOAD: begin
                cnt_d[BIN_QTY-1] = last_bin_cnt;
                rem_d            = cnt_q[0];
                state_d          = EMIT;
            end

            EMIT: begin
                if (valid_q && pixel_ready_i) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        slot_free = 1'b1;
                    end
                end else if (!valid_q) begin
                    slot_free = 1'b1;
                end

                // Refill the output slot; a zero remaining count costs one bubble.
                if (slot_free) begin
                    if (rem_q == '0) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        bin_d   = bin_nx;
                        rem_d   = cnt_q[bin_nx];
                    end else begin
                        valid_d   = 1'b1;
                        pixel_d   = rgb_q[bin_q];
                        index_d   = pix_cnt_q;
                        last_d    = (pix_cnt_q == CW'(LEDS - 1));
                        pix_cnt_d = pix_cnt_q + CW'(1);
                        // Step to the next bin together with its last pixel so
                        // non-empty bins stream back to back.
                        if (rem_q == CW'(1)) begin
                            bin_d = bin_nx;
                            rem_d = cnt_q[bin_nx];
                        end else begin
                            rem_d = rem_q - CW'(1);
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rgb_q     <= '0;
            cnt_q     <= '0;
            bin_q     <= '0;
            rem_q     <= '0;
            pix_cnt_q <= '0;
            pixel_q   <= '0;
            index_q   <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rgb_q     <= rgb_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            rem_q     <= rem_d;
            pix_cnt_q <= pix_cnt_d;
            pixel_q   <= pixel_d;
            index_q   <= index_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign pixel_o       = pixel_q;
    assign pixel_index_o = index_q;
    assign pixel_valid_o = valid_q;
    assign pixel_last_o  = last_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_led_frame_expander.sv
// Randomized bench for led_frame_expander: each frame is checked against an
// expected pixel list built directly from the bin counts and colors.
module tb_led_frame_expander;

    localparam int LEDS    = 50;
    localparam int BIN_QTY = 12;
    localparam int CW      = $clog2(LEDS);

    logic                        clk = 1'b0;
    logic                        rst;
    logic [BIN_QTY-1:0][23:0]    rgb_i;
    logic [BIN_QTY-2:0][CW-1:0]  cnt_i;
    logic                        start_i;
    logic [23:0]                 pixel_o;
    logic [CW-1:0]               pixel_index_o;
    logic                        pixel_valid_o;
    logic                        pixel_last_o;
    logic                        pixel_ready_i;
    logic                        busy_o;
    logic                        done_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] exp_pix [LEDS];
    int          exp_bubbles;
    int          exp_lead;

    always #5 clk = ~clk;

    led_frame_expander #(
        .LEDS    (LEDS),
        .BIN_QTY (BIN_QTY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rgb_i         (rgb_i),
        .LEDCounts_i   (cnt_i),
        .start_i       (start_i),
        .pixel_o       (pixel_o),
        .pixel_index_o (pixel_index_o),
        .pixel_valid_o (pixel_valid_o),
        .pixel_last_o  (pixel_last_o),
        .pixel_ready_i (pixel_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected stream: each bin repeated by its count, last bin fills up to LEDS,
    // output truncated at LEDS. Zero-count bins reached before the end are bubbles.
    function automatic void build_ref();
        int sum;
        int n;
        int c;
        sum = 0;
        n = 0;
        exp_bubbles = 0;
        exp_lead = 0;
        for (int k = 0; k < BIN_QTY - 1; k++) sum += int'(cnt_i[k]);
        for (int k = 0; k < BIN_QTY; k++) begin
            if (n >= LEDS) break;
            if (k < BIN_QTY - 1) c = int'(cnt_i[k]);
            else c = (sum < LEDS) ? LEDS - sum : 0;
            if (c == 0) begin
                exp_bubbles++;
                if (n == 0) exp_lead++;
            end
            for (int j = 0; j < c && n < LEDS; j++) begin
                exp_pix[n] = rgb_i[k];
                n++;
            end
        end
    endfunction

    task automatic run_frame(input string name, input bit bp, input int rst_at, input int poke_at);
        int cyc;
        int got;
        int first;
        int last_cyc;
        int stall7;
        bit stalled;
        bit rdy;
        bit fin;
        logic [23:0]   prev_pix;
        logic [CW-1:0] prev_idx;

        build_ref();
        cyc = 0; got = 0; first = -1; last_cyc = -1; stall7 = 0;
        stalled = 1'b0; fin = 1'b0; prev_pix = '0; prev_idx = '0;

        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check({name, ":busy_rise"}, 64'(busy_o), 64'd1);

        while (!fin) begin
            if (cyc > 1000) begin
                check({name, ":timeout_pixels"}, 64'(got), 64'(LEDS));
                fin = 1'b1;
            end else if (rst_at >= 0 && got == rst_at && pixel_valid_o) begin
                rst = 1'b1;
                #1;
                check({name, ":rst_outputs"},
                      64'({pixel_o, pixel_index_o, pixel_valid_o, pixel_last_o, busy_o, done_o}), 64'd0);
                step();
                check({name, ":rst_no_done"}, 64'({busy_o, done_o}), 64'd0);
                rst = 1'b0;
                step();
                check({name, ":rst_idle"}, 64'({busy_o, done_o, pixel_valid_o}), 64'd0);
                fin = 1'b1;
            end else if (done_o) begin
                check({name, ":done_timing"}, 64'(cyc), 64'(last_cyc + 1));
                check({name, ":pixel_count"}, 64'(got), 64'(LEDS));
                check({name, ":busy_in_done"}, 64'(busy_o), 64'd1);
                step();
                cyc++;
                check({name, ":busy_fall"}, 64'(busy_o), 64'd0);
                check({name, ":done_pulse"}, 64'(done_o), 64'd0);
                fin = 1'b1;
            end else begin
                check({name, ":busy"}, 64'(busy_o), 64'd1);
                if (stalled) begin
                    check({name, ":valid_hold"}, 64'(pixel_valid_o), 64'd1);
                    check({name, ":pix_hold"}, 64'(pixel_o), 64'(prev_pix));
                    check({name, ":idx_hold"}, 64'(pixel_index_o), 64'(prev_idx));
                end
                check({name, ":last_flag"}, 64'(pixel_last_o),
                      64'(pixel_valid_o && (pixel_index_o == CW'(LEDS - 1))));
                if (pixel_valid_o && first < 0) first = cyc;

                rdy = 1'b1;
                if (bp) begin
                    if (pixel_valid_o && pixel_index_o == CW'(7) && stall7 < 3) begin
                        rdy = 1'b0;
                        stall7++;
                    end else begin
                        rdy = ($urandom_range(0, 3) != 0);
                    end
                end
                pixel_ready_i = rdy;

                if (poke_at >= 0 && got == poke_at && pixel_valid_o) begin
                    start_i = 1'b1;
                    for (int k = 0; k < BIN_QTY; k++) rgb_i[k] = 24'($urandom);
                    for (int k = 0; k < BIN_QTY - 1; k++) cnt_i[k] = CW'($urandom_range(0, 8));
                end else begin
                    start_i = 1'b0;
                end

                if (pixel_valid_o && rdy) begin
                    if (got < LEDS) begin
                        check({name, ":index"}, 64'(pixel_index_o), 64'(got));
                        check({name, ":color"}, 64'(pixel_o), 64'(exp_pix[got]));
                    end else begin
                        check({name, ":extra_pixel"}, 64'(got), 64'(LEDS - 1));
                    end
                    got++;
                    last_cyc = cyc;
                end
                stalled  = pixel_valid_o && !rdy;
                prev_pix = pixel_o;
                prev_idx = pixel_index_o;
                step();
                cyc++;
            end
        end

        if (rst_at < 0) begin
            check({name, ":first_valid"}, 64'(first), 64'(2 + exp_lead));
            if (!bp)
                check({name, ":frame_span"}, 64'(last_cyc - first),
                      64'(LEDS - 1 + exp_bubbles - exp_lead));
        end
        start_i = 1'b0;
        pixel_ready_i = 1'b1;

        for (int i = 0; i < 3; i++) begin
            check({name, ":stay_idle"}, 64'({busy_o, done_o}), 64'd0);
            step();
        end
        $display("frame %s: %0d pixels, first valid cycle %0d, %0d bubbles expected",
                 name, got, first, exp_bubbles);
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        pixel_ready_i = 1'b1;
        rgb_i = '0;
        cnt_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state",
              64'({pixel_o, pixel_index_o, pixel_valid_o, pixel_last_o, busy_o, done_o}), 64'd0);
        rst = 1'b0;
        step();
        check("idle_after_reset", 64'({busy_o, done_o}), 64'd0);

        for (int k = 0; k < BIN_QTY; k++) rgb_i[k] = 24'(k * 24'h010101);
        for (int k = 0; k < BIN_QTY - 1; k++) cnt_i[k] = CW'(4);
        run_frame("nominal", 1'b0, -1, -1);

        cnt_i = '0;
        cnt_i[2] = CW'(10);
        run_frame("zero_counts", 1'b0, -1, -1);

        for (int k = 0; k < BIN_QTY - 1; k++) cnt_i[k] = CW'(5);
        run_frame("overflow", 1'b0, -1, -1);

        for (int k = 0; k < BIN_QTY; k++) rgb_i[k] = 24'($urandom);
        for (int k = 0; k < BIN_QTY - 1; k++) cnt_i[k] = CW'($urandom_range(0, 8));
        run_frame("backpressure", 1'b1, -1, -1);

        for (int k = 0; k < BIN_QTY - 1; k++) cnt_i[k] = CW'(4);
        run_frame("reset_mid", 1'b0, 20, -1);
        run_frame("after_reset", 1'b0, -1, -1);

        run_frame("start_busy", 1'b0, -1, 10);

        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < BIN_QTY; k++) rgb_i[k] = 24'($urandom);
            for (int k = 0; k < BIN_QTY - 1; k++)
                cnt_i[k] = CW'($urandom_range(0, (f % 3 == 2) ? 20 : 8));
            run_frame($sformatf("random%0d", f), 1'(f % 2), -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
